// File: rtl/dac_mode_sequencer_if.sv
// MCU mode/control lines in, DAC and PLL control pins out.
interface dac_mode_sequencer_if;
  logic       mcu_44_48;
  logic [1:0] mcu_f;
  logic       mcu_dsd_on;
  logic       mcu_mute;
  logic       mcu_dac_reset;
  logic       dac_44_48;
  logic [1:0] dac_f;
  logic       dac_dsd;
  logic       dac_mute;
  logic       dac_reset;
  logic [1:0] pll_s;
  logic       busy;

  modport master (
    output mcu_44_48, mcu_f, mcu_dsd_on, mcu_mute, mcu_dac_reset,
    input  dac_44_48, dac_f, dac_dsd, dac_mute, dac_reset, pll_s, busy
  );

  modport slave (
    input  mcu_44_48, mcu_f, mcu_dsd_on, mcu_mute, mcu_dac_reset,
    output dac_44_48, dac_f, dac_dsd, dac_mute, dac_reset, pll_s, busy
  );
endinterface

// File: rtl/dac_mode_sequencer.sv
// Glitch-free DAC/PLL reconfiguration: debounce MCU mode lines, then
// mute -> reset with new mode/PLL select -> release -> unmute.
module dac_mode_sequencer #(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned MUTE_CYC   = 4096,
  parameter int unsigned PLL_CYC    = 65536,
  parameter int unsigned SETTLE_CYC = 4096,
  parameter int unsigned CNT_W      = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dac_mode_sequencer_if.slave  bus
);

  localparam int unsigned SCNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SCNT_MAX   = SCNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]  LOAD_MUTE  = CNT_W'(MUTE_CYC - 1);
  localparam logic [CNT_W-1:0]  LOAD_PLL   = CNT_W'(PLL_CYC - 1);
  localparam logic [CNT_W-1:0]  LOAD_SETTLE = CNT_W'(SETTLE_CYC - 1);

  typedef struct packed {
    logic       fam;
    logic [1:0] f;
    logic       dsd_on;
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUTE,
    S_RESET,
    S_RELEASE
  } state_t;

  mode_t             raw;
  mode_t             cand;
  mode_t             smode;
  mode_t             applied;
  mode_t             applied_nxt;
  logic [SCNT_W-1:0] scnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  state_t            state;
  state_t            state_nxt;
  logic              mute_nxt;
  logic              reset_nxt;
  logic              busy_nxt;

  assign raw = {bus.mcu_44_48, bus.mcu_f, bus.mcu_dsd_on};

  // Mode filter: smode follows raw only after it has held for STABLE_CYC+1 edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand  <= '0;
      scnt  <= '0;
      smode <= '0;
    end else if (raw != cand) begin
      cand <= raw;
      scnt <= '0;
    end else if (scnt == SCNT_MAX) begin
      smode <= cand;
    end else begin
      scnt <= scnt + SCNT_W'(1);
    end
  end

  // Next-state, wait counter and registered-output next values
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    applied_nxt = applied;
    unique case (state)
      S_IDLE: begin
        if ((smode != applied) || bus.mcu_dac_reset) begin
          state_nxt = S_MUTE;
          cnt_nxt   = LOAD_MUTE;
        end
      end
      S_MUTE: begin
        if (cnt == '0) begin
          state_nxt   = S_RESET;
          cnt_nxt     = LOAD_PLL;
          applied_nxt = smode;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RESET: begin
        if (bus.mcu_dac_reset) begin
          cnt_nxt = LOAD_PLL;
        end else if (cnt == '0) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = LOAD_SETTLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // A late mode change re-latches straight from reset; mute is already held
        if (bus.mcu_dac_reset || ((cnt == '0) && (smode != applied))) begin
          state_nxt   = S_RESET;
          cnt_nxt     = LOAD_PLL;
          applied_nxt = smode;
        end else if (cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_RESET;
        cnt_nxt   = LOAD_PLL;
      end
    endcase
    busy_nxt  = (state_nxt != S_IDLE);
    reset_nxt = (state_nxt == S_RESET);
    // Unmute is only possible once IDLE has been entered for a full cycle
    mute_nxt  = !((state == S_IDLE) && (state_nxt == S_IDLE)) || bus.mcu_mute;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_RESET;
      cnt           <= LOAD_PLL;
      applied       <= '0;
      bus.dac_44_48 <= 1'b0;
      bus.dac_f     <= 2'b00;
      bus.dac_dsd   <= 1'b1;
      bus.pll_s     <= 2'b00;
      bus.dac_mute  <= 1'b1;
      bus.dac_reset <= 1'b1;
      bus.busy      <= 1'b1;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      applied       <= applied_nxt;
      bus.dac_44_48 <= applied_nxt.fam;
      bus.dac_f     <= applied_nxt.f;
      bus.dac_dsd   <= ~applied_nxt.dsd_on;
      bus.pll_s     <= {applied_nxt.dsd_on, applied_nxt.fam};
      bus.dac_mute  <= mute_nxt;
      bus.dac_reset <= reset_nxt;
      bus.busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_dac_mode_sequencer.sv
// Scoreboard bench: expected output snapshots queued per cycle, checked at negedge.
module tb_dac_mode_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   a;

  dac_mode_sequencer_if bus ();

  dac_mode_sequencer #(
    .STABLE_CYC (4),
    .MUTE_CYC   (8),
    .PLL_CYC    (16),
    .SETTLE_CYC (8),
    .CNT_W      (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         c;
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t q[$];

  localparam logic [3:0] M0 = 4'b0_00_0;
  localparam logic [3:0] M1 = 4'b1_10_1;
  localparam logic [3:0] M2 = 4'b0_10_1;
  localparam logic [3:0] M3 = 4'b0_01_0;

  logic [8:0] outs;
  assign outs = {bus.busy, bus.dac_mute, bus.dac_reset, bus.dac_44_48,
                 bus.dac_f, bus.dac_dsd, bus.pll_s};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, want);
    end
  endtask

  // {busy, mute, reset, 44_48, f, dsd, pll_s} for a given applied mode {44_48,f,dsd_on}
  function automatic logic [8:0] ov(input logic b, input logic mu, input logic rs,
                                    input logic [3:0] m);
    return {b, mu, rs, m[3], m[2:1], ~m[0], m[0], m[3]};
  endfunction

  task automatic exp_rng(input int c0, input int c1, input string tag, input logic [8:0] v);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.c = c;
      e.tag = tag;
      e.v = v;
      q.push_back(e);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_mode(input logic [3:0] m);
    {bus.mcu_44_48, bus.mcu_f, bus.mcu_dsd_on} = m;
  endtask

  always @(negedge clk) begin
    for (int i = int'(q.size()) - 1; i >= 0; i--) begin
      if (q[i].c == cyc) begin
        check(q[i].tag, 32'(outs), 32'(q[i].v));
        q.delete(i);
      end
    end
  end

  initial begin
    cyc = 0;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    set_mode(M0);
    bus.mcu_mute = 1'b0;
    bus.mcu_dac_reset = 1'b0;

    // power-up
    exp_rng(1, 3, "rst", ov(1, 1, 1, M0));
    wait_to(3);
    rst_n = 1'b1;
    a = cyc;
    exp_rng(a + 1,  a + 15, "pu_reset",  ov(1, 1, 1, M0));
    exp_rng(a + 16, a + 23, "pu_rel",    ov(1, 1, 0, M0));
    exp_rng(a + 24, a + 24, "pu_idle",   ov(0, 1, 0, M0));
    exp_rng(a + 25, a + 28, "pu_unmute", ov(0, 0, 0, M0));
    wait_to(a + 30);

    // mode change
    a = cyc;
    set_mode(M1);
    exp_rng(a + 1,  a + 5,  "mc_filt",   ov(0, 0, 0, M0));
    exp_rng(a + 6,  a + 13, "mc_mute",   ov(1, 1, 0, M0));
    exp_rng(a + 14, a + 29, "mc_reset",  ov(1, 1, 1, M1));
    exp_rng(a + 30, a + 37, "mc_rel",    ov(1, 1, 0, M1));
    exp_rng(a + 38, a + 38, "mc_idle",   ov(0, 1, 0, M1));
    exp_rng(a + 39, a + 41, "mc_unmute", ov(0, 0, 0, M1));
    wait_to(a + 42);

    // short glitch on mcu_f
    a = cyc;
    bus.mcu_f = 2'b00;
    exp_rng(a + 1, a + 16, "glitch", ov(0, 0, 0, M1));
    wait_to(a + 3);
    bus.mcu_f = 2'b10;
    wait_to(a + 17);

    // change arriving during RELEASE
    a = cyc;
    set_mode(M2);
    exp_rng(a + 1,  a + 5,  "rc_filt",   ov(0, 0, 0, M1));
    exp_rng(a + 6,  a + 13, "rc_mute",   ov(1, 1, 0, M1));
    exp_rng(a + 14, a + 29, "rc_reset1", ov(1, 1, 1, M2));
    exp_rng(a + 30, a + 37, "rc_rel1",   ov(1, 1, 0, M2));
    exp_rng(a + 38, a + 53, "rc_reset2", ov(1, 1, 1, M1));
    exp_rng(a + 54, a + 61, "rc_rel2",   ov(1, 1, 0, M1));
    exp_rng(a + 62, a + 62, "rc_idle",   ov(0, 1, 0, M1));
    exp_rng(a + 63, a + 63, "rc_unmute", ov(0, 0, 0, M1));
    wait_to(a + 31);
    bus.mcu_44_48 = 1'b1;
    wait_to(a + 64);

    // forced DAC reset held 40 cycles
    a = cyc;
    bus.mcu_dac_reset = 1'b1;
    exp_rng(a + 1,  a + 8,  "fr_mute",   ov(1, 1, 0, M1));
    exp_rng(a + 9,  a + 55, "fr_reset",  ov(1, 1, 1, M1));
    exp_rng(a + 56, a + 63, "fr_rel",    ov(1, 1, 0, M1));
    exp_rng(a + 64, a + 64, "fr_idle",   ov(0, 1, 0, M1));
    exp_rng(a + 65, a + 65, "fr_unmute", ov(0, 0, 0, M1));
    wait_to(a + 40);
    bus.mcu_dac_reset = 1'b0;
    wait_to(a + 66);

    // mute passthrough
    a = cyc;
    bus.mcu_mute = 1'b1;
    exp_rng(a + 1, a + 3, "mp_on", ov(0, 1, 0, M1));
    wait_to(a + 3);
    bus.mcu_mute = 1'b0;
    exp_rng(a + 4, a + 5, "mp_off", ov(0, 0, 0, M1));
    wait_to(a + 6);

    // rst_n asserted mid-RESET, then power-up sequence with pending mode
    a = cyc;
    set_mode(M3);
    exp_rng(a + 1,  a + 5,  "mr_filt",  ov(0, 0, 0, M1));
    exp_rng(a + 6,  a + 13, "mr_mute",  ov(1, 1, 0, M1));
    exp_rng(a + 14, a + 20, "mr_reset", ov(1, 1, 1, M3));
    wait_to(a + 20);
    rst_n = 1'b0;
    exp_rng(a + 21, a + 22, "mr_rstval", ov(1, 1, 1, M0));
    wait_to(a + 22);
    rst_n = 1'b1;
    exp_rng(a + 23, a + 37, "mr_pu_reset", ov(1, 1, 1, M0));
    exp_rng(a + 38, a + 45, "mr_pu_rel",   ov(1, 1, 0, M0));
    exp_rng(a + 46, a + 61, "mr_relatch",  ov(1, 1, 1, M3));
    exp_rng(a + 62, a + 69, "mr_rel",      ov(1, 1, 0, M3));
    exp_rng(a + 70, a + 70, "mr_idle",     ov(0, 1, 0, M3));
    exp_rng(a + 71, a + 72, "mr_unmute",   ov(0, 0, 0, M3));
    wait_to(a + 74);

    check("sb_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
